average_filter_core: RTL and testbench

AVERAGE_FILTER_CORE -- requirements
Module: average_filter

---
 rtl/average_filter_core_pkg.sv | 4 +
 rtl/average_filter_core.sv | 40 ++++
 tb/tb_average_filter_core.sv | 137 +++++++++++++
 3 files changed

// File: rtl/average_filter_core_pkg.sv
// average_filter_core_pkg: shared constants for the two-tap averaging filter
package average_filter_core_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
endpackage

// File: rtl/average_filter_core.sv
// average_filter_core: two-tap moving average with floor-rounded halving and a delayed valid strobe
module average_filter_core
    import average_filter_core_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_ce,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         o_ce
);
    logic signed [DATA_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d, avg_q, avg_d;
    logic                         o_ce_q, o_ce_d;
    logic signed [DATA_WIDTH:0]   sum;
    always_comb begin
        // one extra bit keeps the sum exact; halving it always fits back into DATA_WIDTH
        sum    = {x0_q[DATA_WIDTH-1], x0_q} + {x1_q[DATA_WIDTH-1], x1_q};
        x0_d   = i_ce ? data_in : x0_q;
        x1_d   = i_ce ? x0_q : x1_q;
        avg_d  = i_ce ? DATA_WIDTH'(sum >>> 1) : avg_q;
        o_ce_d = i_ce;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q   <= '0;
            x1_q   <= '0;
            avg_q  <= '0;
            o_ce_q <= 1'b0;
        end else begin
            x0_q   <= x0_d;
            x1_q   <= x1_d;
            avg_q  <= avg_d;
            o_ce_q <= o_ce_d;
        end
    end
    assign data_out = avg_q;
    assign o_ce     = o_ce_q;
endmodule

// File: tb/tb_average_filter_core.sv
// tb_average_filter_core: directed and random checks against a sample-history reference model
module tb_average_filter_core;
    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_ce = 1'b0;
    logic signed [7:0] data_in = '0;
    logic signed [7:0] data_out;
    logic              o_ce;
    int                total = 0;
    int                failed = 0;
    int                hist[$];
    int                exp_out = 0;
    bit                exp_ce = 1'b0;

    average_filter_core #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .i_ce(i_ce),
        .data_in(data_in), .data_out(data_out), .o_ce(o_ce)
    );

    always #5 clk = ~clk;

    function automatic int floor_half(input int s);
        return (s < 0 && (s % 2) != 0) ? s / 2 - 1 : s / 2;
    endfunction

    function automatic logic signed [7:0] to8(input int v);
        return v[7:0];
    endfunction

    task automatic model_reset();
        hist = '{0, 0};
        exp_out = 0;
        exp_ce = 1'b0;
    endtask

    task automatic check(input string tag, input int want_out, input bit want_ce);
        total += 2;
        assert (data_out === to8(want_out)) else begin
            failed++;
            $error("FAIL %s data_out got %0d want %0d", tag, data_out, to8(want_out));
        end
        assert (o_ce === want_ce) else begin
            failed++;
            $error("FAIL %s o_ce got %0b want %0b", tag, o_ce, want_ce);
        end
    endtask

    task automatic step(input bit ce, input int din, input string tag);
        i_ce = ce;
        data_in = to8(din);
        @(posedge clk);
        if (ce) begin
            exp_out = floor_half(hist[$] + hist[$-1]);
            hist.push_back(din);
        end
        exp_ce = ce;
        #1;
        check(tag, exp_out, exp_ce);
    endtask

    task automatic expect_value(input string tag, input int want);
        total++;
        assert (data_out === to8(want)) else begin
            failed++;
            $error("FAIL %s directed got %0d want %0d", tag, data_out, to8(want));
        end
    endtask

    initial begin
        int seq[8] = '{-20, 30, -40, 50, 0, 100, -127, 127};
        int want[8] = '{-5, 5, -5, 5, 25, 50, -14, 0};
        model_reset();
        for (int i = 0; i < 6; i++) begin
            i_ce = 1'($urandom);
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", 0, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 10, "hold10");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq[i], "seq_a");
            step(1'b1, seq[i], "seq_b");
            expect_value("seq_window", want[i]);
        end
        step(1'b1, 127, "pos_a"); step(1'b1, 127, "pos_b"); step(1'b1, 127, "pos_c");
        expect_value("pos_max", 127);
        step(1'b1, -128, "neg_a"); step(1'b1, -128, "neg_b"); step(1'b1, -128, "neg_c");
        expect_value("neg_min", -128);
        step(1'b1, 127, "mix_a"); step(1'b1, -60, "mix_b"); step(1'b1, 0, "mix_c");
        expect_value("mix_floor", 33);
        step(1'b0, 0, "idle0");
        step(1'b1, 40, "pulse40");
        step(1'b0, 99, "idle1");
        step(1'b0, -99, "idle2");
        step(1'b1, 20, "pulse20");
        step(1'b0, 55, "idle3");
        step(1'b1, 0, "pulse0");
        expect_value("pulse_avg", 30);
        step(1'b0, 7, "idle4");
        step(1'b1, 100, "h100a"); step(1'b1, 100, "h100b");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_assert", 0, 1'b0);
        @(posedge clk);
        #1;
        check("in_reset", 0, 1'b0);
        reset_n = 1'b1;
        step(1'b1, 50, "post_rst_a");
        expect_value("post_rst_a", 0);
        step(1'b1, 50, "post_rst_b");
        expect_value("post_rst_b", 25);
        for (int i = 0; i < 3; i++) step(1'b1, -1, "fill_m1");
        expect_value("m1_avg", -1);
        step(1'b1, -2, "m2_a");
        step(1'b1, -2, "m2_b");
        expect_value("m2_floor", -2);
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst", 0, 1'b0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            step(1'($urandom_range(0, 3) != 0), $signed(8'($urandom)), "random");
        end
        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
